// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and arbitration encoding for spram_fifo_ctrl
package fifo_pkg;
  localparam int DATA_WIDTH = 12;
  localparam int ADDR_WIDTH = 6;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;
endpackage

// File: rtl/spram_fifo_ctrl_if.sv
// rtl/spram_fifo_ctrl_if.sv - write/read stream and status bundle of spram_fifo_ctrl
interface spram_fifo_ctrl_if #(
  parameter int data_width = fifo_pkg::DATA_WIDTH,
  parameter int addr_width = fifo_pkg::ADDR_WIDTH
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [data_width-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [data_width-1:0] rd_data;
  logic [addr_width:0]   count;
  logic                  full;
  logic                  empty;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, count, full, empty
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, count, full, empty
  );
endinterface

// File: rtl/sp_ram.sv
// rtl/sp_ram.sv - single-port synchronous RAM, read data appears the cycle after the access
module sp_ram #(
  parameter int                    data_width = 12,
  parameter int                    addr_width = 6,
  parameter logic [data_width-1:0] init_value = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [addr_width-1:0] addr,
  input  logic [data_width-1:0] data_in,
  output logic [data_width-1:0] data_out
);
  logic [data_width-1:0] mem [2**addr_width];
  logic [data_width-1:0] data_out_q;
  logic [data_width-1:0] data_out_d;

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= data_in;
  end

  always_comb begin
    data_out_d = data_out_q;
    if (!we) data_out_d = mem[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_out_q <= init_value;
    else        data_out_q <= data_out_d;
  end

  assign data_out = data_out_q;
endmodule

// File: rtl/spram_fifo_ctrl.sv
// rtl/spram_fifo_ctrl.sv - FIFO over one sp_ram; writes and read prefetches share the port
module spram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int addr_width = ADDR_WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  spram_fifo_ctrl_if.slave  bus
);
  localparam logic [addr_width:0] cnt_full = {1'b1, {addr_width{1'b0}}};

  logic [addr_width-1:0] wptr_q, wptr_d;
  logic [addr_width-1:0] rptr_q, rptr_d;
  logic [addr_width:0]   ram_cnt_q, ram_cnt_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic                  out_valid_q, out_valid_d;
  logic [data_width-1:0] rd_data_q, rd_data_d;
  grant_e                last_winner_q, last_winner_d;

  logic                  full, wr_req, rd_req, grant_wr, grant_rd;
  logic [addr_width-1:0] ram_addr;
  logic [data_width-1:0] ram_dout;
  logic [addr_width:0]   count;

  always_comb begin
    full          = (ram_cnt_q == cnt_full);
    wr_req        = rst_n && bus.wr_valid && !full;
    rd_req        = rst_n && (ram_cnt_q != '0) && !rd_inflight_q && (!out_valid_q || bus.rd_ready);
    grant_wr      = wr_req;
    grant_rd      = rd_req;
    last_winner_d = last_winner_q;
    // On a conflict the side that lost last time wins; last_winner moves only here.
    if (wr_req && rd_req) begin
      grant_wr      = (last_winner_q == GRANT_RD);
      grant_rd      = !grant_wr;
      last_winner_d = grant_wr ? GRANT_WR : GRANT_RD;
    end
  end

  always_comb begin
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    ram_cnt_d     = ram_cnt_q;
    rd_inflight_d = grant_rd;
    out_valid_d   = out_valid_q;
    rd_data_d     = rd_data_q;
    if (grant_wr) begin
      wptr_d    = wptr_q + 1'b1;
      ram_cnt_d = ram_cnt_q + 1'b1;
    end else if (grant_rd) begin
      rptr_d    = rptr_q + 1'b1;
      ram_cnt_d = ram_cnt_q - 1'b1;
    end
    // A capture refills the output register even if it is popped this cycle.
    if (rd_inflight_q) begin
      out_valid_d = 1'b1;
      rd_data_d   = ram_dout;
    end else if (out_valid_q && bus.rd_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      ram_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      out_valid_q   <= 1'b0;
      rd_data_q     <= '0;
      last_winner_q <= GRANT_RD;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      ram_cnt_q     <= ram_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      out_valid_q   <= out_valid_d;
      rd_data_q     <= rd_data_d;
      last_winner_q <= last_winner_d;
    end
  end

  assign ram_addr = grant_wr ? wptr_q : rptr_q;
  assign count    = ram_cnt_q + {{addr_width{1'b0}}, rd_inflight_q}
                              + {{addr_width{1'b0}}, out_valid_q};

  sp_ram #(
    .data_width (data_width),
    .addr_width (addr_width),
    .init_value ('0)
  ) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (grant_wr),
    .addr     (ram_addr),
    .data_in  (bus.wr_data),
    .data_out (ram_dout)
  );

  assign bus.wr_ready = grant_wr;
  assign bus.rd_valid = out_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.count    = count;
  assign bus.full     = full;
  assign bus.empty    = (count == '0);
endmodule

// File: doc/spram_fifo_ctrl.md
Name: spram_fifo_ctrl

Overview:
- Synchronous FIFO built around one `sp_ram` instance.
- Upstream side is a valid/ready write stream; downstream side is a valid/ready read stream with a registered output stage.
- Arbitrates the single RAM port between writes and read prefetches, one access per clock.
- Sits directly upstream of `sp_ram`, owns its `we`/`addr`/`data_in`, and consumes its `data_out`.

Parameters:
- data_width, 12, word width; passed to sp_ram.
- addr_width, 6, RAM address width; RAM depth is 2**addr_width.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write word offered.
- wr_ready  out  1  write accepted this cycle when wr_valid && wr_ready.
- wr_data  in  data_width  write word.
- rd_valid  out  1  rd_data holds a valid word.
- rd_ready  in  1  consumer takes the word when rd_valid && rd_ready.
- rd_data  out  data_width  output register.
- count  out  addr_width+1  total words held (RAM + in-flight + output register).
- full  out  1  RAM occupancy == 2**addr_width.
- empty  out  1  count == 0.

Behaviour:
- Reset (async, rst_n=0), all cleared to 0:
  - Internal: wptr, rptr, ram_cnt, rd_inflight, out_valid, rd_data register.
  - Outputs: wr_ready=0, rd_valid=0, rd_data=0, count=0, full=0, empty=1.
  - last_winner is set to READ, so the first conflict grants the write.
  - RAM contents are not cleared.
- Fixed sp_ram contract: synchronous. A write occurs at the posedge with we=1. A read with we=0 presents data_out in the following cycle.
- Per-cycle requests:
  - rd_req = (ram_cnt!=0) && !rd_inflight && (!out_valid || rd_ready).
  - wr_req = wr_valid && !full.
- Grant:
  - Only one request: that request wins.
  - Both requests: the side opposite last_winner wins, and last_winner updates. last_winner changes only on conflicts.
  - wr_ready = wr_req && grant_wr. This is combinational and is 0 when the read wins a conflict.
- RAM drive:
  - we = grant_wr.
  - addr = grant_wr ? wptr : rptr.
  - data_in = wr_data.
  - Idle cycle: we=0, addr=rptr.
- Write grant: wptr <= wptr+1 (wraps modulo 2**addr_width); ram_cnt +1.
- Read grant: rptr <= rptr+1 (wraps); ram_cnt -1; rd_inflight <= 1.
- ram_cnt never increments and decrements in the same cycle.
- Cycle after a read grant: rd_inflight <= 0; rd_data <= data_out; out_valid <= 1.
- Pop: rd_valid && rd_ready with no capture that cycle clears out_valid. A capture in the same cycle refills the register.
- Latency: write accepted in cycle N, FIFO otherwise empty:
  - Read issued N+1.
  - Captured at the end of N+2.
  - rd_valid=1 in cycle N+3.
- Sustained read throughput is 1 word per 2 cycles (one in-flight read max). This is intended.
- rd_data stays stable while rd_valid && !rd_ready.
- count = ram_cnt + rd_inflight + out_valid; max 2**addr_width+1.
- full depends on ram_cnt only. When full, wr_ready=0 and wr_data is ignored.
- Reset mid-operation: an in-flight read is discarded and pointers return to 0. No spurious rd_valid after rst_n deasserts.

Decomposition:
- Shared package (fifo_pkg): arbitration-winner encoding (GRANT_WR=0, GRANT_RD=1) and the default data_width/addr_width constants.
- One sub-module: sp_ram, instantiated as u_ram with init_value 0.
- Arbiter and pointer logic stay inline.

Test Plan:
- Reset, then one write of 0x001, rd_ready=1 → wr_ready=1 in cycle 0, rd_valid=1 with rd_data=0x001 in cycle 3, count 1→0, empty=1 afterwards.
- Write 0x000..0x03F with rd_ready=0:
  - All 64 words are accepted, with read prefetch interleaved: word 0 moves to the output register.
  - Write 0x040 → also accepted, count=65.
  - full=1; wr_ready=0 while wr_valid=1 and data 0x041 is held.
  - Then drain with rd_ready=1 → 0x000..0x040 out in order.
- Continuous wr_valid plus continuous rd_ready across 200 words → grants alternate on conflict, pointers wrap past 63→0, output sequence is identical to input, and there are no drops or duplicates.
- rd_ready=0 for 10 cycles with rd_valid=1 and rd_data=0x123 → rd_data stays 0x123 and count stays constant with no writes.
- Assert rst_n=0 one cycle after a read grant with 5 words stored → all outputs reach reset values immediately, rd_valid stays 0 after release, and the next write of 0xABC reads back 0xABC.
